// File: rtl/ghost_dist_map.sv
// BFS distance-map builder for the ghost controller: floods step counts from
// pacman's tile over the wall map and serves them through a registered read port.
module ghost_dist_map #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int QDEPTH = 2048
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [5:0] curr_pacman_x,
    input  logic [4:0] curr_pacman_y,
    output logic [5:0] wall_rdaddr_x,
    output logic [4:0] wall_rdaddr_y,
    input  logic       wall_data,
    input  logic [5:0] rdaddr_x,
    input  logic [4:0] rdaddr_y,
    output logic [7:0] data,
    output logic       ready
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int QW    = $clog2(QDEPTH);

    typedef enum logic [2:0] {S_CLEAR, S_SEED, S_POP, S_NADDR, S_NCHK, S_DONE} state_t;
    typedef struct packed { logic [5:0] x; logic [4:0] y; logic [7:0] d; } qent_t;
    typedef struct packed { logic valid; logic [5:0] x; logic [4:0] y; } nbr_t;

    function automatic logic in_grid(input logic [5:0] x, input logic [4:0] y);
        return (int'(x) < COLS) && (int'(y) < ROWS);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
        return AW'(y) * AW'(COLS) + AW'(x);
    endfunction

    // Neighbour order is up, down, left, right; off-grid slots are flagged invalid, never wrapped.
    function automatic nbr_t nbr(input logic [5:0] x, input logic [4:0] y, input logic [1:0] idx);
        nbr_t n;
        n.x = x;
        n.y = y;
        case (idx)
            2'd0:    begin n.y = y - 5'd1; n.valid = (y != 5'd0);          end
            2'd1:    begin n.y = y + 5'd1; n.valid = (int'(y) + 1 < ROWS); end
            2'd2:    begin n.x = x - 6'd1; n.valid = (x != 6'd0);          end
            2'd3:    begin n.x = x + 6'd1; n.valid = (int'(x) + 1 < COLS); end
            default: n.valid = 1'b0;
        endcase
        return n;
    endfunction

    state_t        r_state, w_next;
    logic [5:0]    r_tx, r_cx, r_nx;
    logic [4:0]    r_ty, r_cy, r_ny;
    logic [7:0]    r_cd, r_ndist, r_data;
    logic [AW-1:0] r_clr_cnt;
    logic [1:0]    r_nidx;
    logic          r_nvalid, r_ready;
    logic [QW-1:0] r_qhead, r_qtail;
    logic [7:0]    r_dist [CELLS];
    qent_t         r_queue [QDEPTH];

    logic          w_trigger, w_q_empty, w_seed_ok, w_fresh, w_we, w_push;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata, w_nd;
    qent_t         w_qhead_ent, w_push_ent;
    nbr_t          w_nbr_first, w_nbr_next;

    assign w_trigger   = (curr_pacman_x != r_tx) || (curr_pacman_y != r_ty);
    assign w_q_empty   = (r_qhead == r_qtail);
    assign w_qhead_ent = r_queue[r_qhead];
    assign w_seed_ok   = in_grid(r_tx, r_ty);
    assign w_fresh     = r_nvalid && !wall_data && (r_ndist == 8'd255);
    assign w_nd        = (r_cd >= 8'd254) ? 8'd254 : r_cd + 8'd1;
    assign w_nbr_first = nbr(w_qhead_ent.x, w_qhead_ent.y, 2'd0);
    assign w_nbr_next  = nbr(r_cx, r_cy, r_nidx + 2'd1);

    // Next-state, RAM write strobe and queue push decode; a pacman move pre-empts everything.
    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_waddr    = '0;
        w_wdata    = 8'd255;
        w_push     = 1'b0;
        w_push_ent = '0;
        if (w_trigger) begin
            w_next = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_we    = 1'b1;
                    w_waddr = r_clr_cnt;
                    w_wdata = 8'd255;
                    if (r_clr_cnt == AW'(CELLS - 1)) w_next = S_SEED;
                    else                             w_next = S_CLEAR;
                end
                S_SEED: begin
                    if (w_seed_ok) begin
                        w_we       = 1'b1;
                        w_waddr    = cell_addr(r_tx, r_ty);
                        w_wdata    = 8'd0;
                        w_push     = 1'b1;
                        w_push_ent = '{x: r_tx, y: r_ty, d: 8'd0};
                        w_next     = S_POP;
                    end else begin
                        w_next = S_DONE;
                    end
                end
                S_POP:   w_next = w_q_empty ? S_DONE : S_NADDR;
                S_NADDR: w_next = S_NCHK;
                S_NCHK: begin
                    if (w_fresh) begin
                        w_we       = 1'b1;
                        w_waddr    = cell_addr(r_nx, r_ny);
                        w_wdata    = w_nd;
                        w_push     = 1'b1;
                        w_push_ent = '{x: r_nx, y: r_ny, d: w_nd};
                    end else begin
                        w_push = 1'b0;
                    end
                    w_next = (r_nidx == 2'd3) ? S_POP : S_NADDR;
                end
                S_DONE:  w_next = S_DONE;
                default: w_next = S_CLEAR;
            endcase
        end
    end

    // Control and datapath registers; reset latches an out-of-range target so the first build is forced.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_CLEAR;
            r_tx      <= 6'd63;
            r_ty      <= 5'd31;
            r_clr_cnt <= '0;
            r_cx      <= 6'd0;
            r_cy      <= 5'd0;
            r_cd      <= 8'd0;
            r_nx      <= 6'd0;
            r_ny      <= 5'd0;
            r_nidx    <= 2'd0;
            r_nvalid  <= 1'b0;
            r_ndist   <= 8'd255;
            r_qhead   <= '0;
            r_qtail   <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_DONE);
            if (w_trigger) begin
                r_tx      <= curr_pacman_x;
                r_ty      <= curr_pacman_y;
                r_clr_cnt <= '0;
                r_qhead   <= '0;
                r_qtail   <= '0;
            end else begin
                if (w_push) r_qtail <= r_qtail + QW'(1);
                case (r_state)
                    S_CLEAR: r_clr_cnt <= r_clr_cnt + AW'(1);
                    S_POP: begin
                        if (!w_q_empty) begin
                            r_cx     <= w_qhead_ent.x;
                            r_cy     <= w_qhead_ent.y;
                            r_cd     <= w_qhead_ent.d;
                            r_qhead  <= r_qhead + QW'(1);
                            r_nidx   <= 2'd0;
                            r_nx     <= w_nbr_first.x;
                            r_ny     <= w_nbr_first.y;
                            r_nvalid <= w_nbr_first.valid;
                        end else begin
                            r_nvalid <= 1'b0;
                        end
                    end
                    S_NADDR: r_ndist <= r_nvalid ? r_dist[cell_addr(r_nx, r_ny)] : 8'd255;
                    S_NCHK: begin
                        r_nidx   <= r_nidx + 2'd1;
                        r_nx     <= w_nbr_next.x;
                        r_ny     <= w_nbr_next.y;
                        r_nvalid <= w_nbr_next.valid;
                    end
                    default: r_nidx <= r_nidx;
                endcase
            end
        end
    end

    // Distance RAM and BFS queue storage (no reset; CLEAR and pointer reset make contents irrelevant).
    always_ff @(posedge CLOCK_50) begin
        if (w_we)   r_dist[w_waddr]   <= w_wdata;
        if (w_push) r_queue[r_qtail]  <= w_push_ent;
    end

    // Consumer read port, serviced every cycle regardless of build state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)                      r_data <= 8'd255;
        else if (in_grid(rdaddr_x, rdaddr_y)) r_data <= r_dist[cell_addr(rdaddr_x, rdaddr_y)];
        else                               r_data <= 8'd255;
    end

    assign wall_rdaddr_x = r_nx;
    assign wall_rdaddr_y = r_ny;
    assign data          = r_data;
    assign ready         = r_ready;
endmodule

// File: tb/tb_ghost_dist_map.sv
// Directed bench for ghost_dist_map: bench-side wall RAM, table-driven map reads,
// and hand sequences for build timing, mid-build moves and mid-build reset.
module tb_ghost_dist_map;
    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic [5:0] curr_pacman_x = 6'd20;
    logic [4:0] curr_pacman_y = 5'd20;
    logic [5:0] wall_rdaddr_x;
    logic [4:0] wall_rdaddr_y;
    logic       wall_data = 1'b0;
    logic [5:0] rdaddr_x = 6'd0;
    logic [4:0] rdaddr_y = 5'd0;
    logic [7:0] data;
    logic       ready;

    logic walls [64][32];
    int checks   = 0;
    int failures = 0;

    typedef struct { logic [5:0] x; logic [4:0] y; logic [7:0] exp; } rd_vec_t;
    rd_vec_t open_tbl [8];

    ghost_dist_map dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .curr_pacman_x(curr_pacman_x), .curr_pacman_y(curr_pacman_y),
        .wall_rdaddr_x(wall_rdaddr_x), .wall_rdaddr_y(wall_rdaddr_y),
        .wall_data(wall_data), .rdaddr_x(rdaddr_x), .rdaddr_y(rdaddr_y),
        .data(data), .ready(ready)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) wall_data <= walls[wall_rdaddr_x][wall_rdaddr_y];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic read_chk(input string name, input logic [5:0] x, input logic [4:0] y, input int exp);
        @(negedge CLOCK_50);
        rdaddr_x = x;
        rdaddr_y = y;
        @(posedge CLOCK_50);
        #1;
        check(name, int'(data), exp);
    endtask

    task automatic wait_ready(input string name, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 15000; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (ready) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic rebuild(input logic [5:0] x, input logic [4:0] y);
        @(negedge CLOCK_50);
        curr_pacman_x = 6'd0;
        curr_pacman_y = 5'd0;
        @(negedge CLOCK_50);
        curr_pacman_x = x;
        curr_pacman_y = y;
    endtask

    task automatic clear_walls();
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                walls[x][y] = 1'b0;
    endtask

    initial begin
        int cyc;
        open_tbl[0] = '{6'd16, 5'd13, 8'd11};
        open_tbl[1] = '{6'd0,  5'd0,  8'd40};
        open_tbl[2] = '{6'd20, 5'd20, 8'd0};
        open_tbl[3] = '{6'd39, 5'd29, 8'd28};
        open_tbl[4] = '{6'd20, 5'd19, 8'd1};
        open_tbl[5] = '{6'd63, 5'd13, 8'd255};
        open_tbl[6] = '{6'd16, 5'd31, 8'd255};
        open_tbl[7] = '{6'd40, 5'd0,  8'd255};
        clear_walls();

        // Reset state and first build timing
        #22;
        check("reset_ready", int'(ready), 0);
        check("reset_data", int'(data), 255);
        check("reset_wall_addr", int'({wall_rdaddr_x, wall_rdaddr_y}), 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        wait_ready("first_build", cyc);
        check("first_build_lo", int'(cyc >= 12001), 1);
        check("first_build_hi", int'(cyc <= 12004), 1);

        for (int i = 0; i < 8; i++)
            read_chk($sformatf("open_rd%0d", i), open_tbl[i].x, open_tbl[i].y, int'(open_tbl[i].exp));

        // Back-to-back reads: each answer belongs to the address one cycle earlier
        @(negedge CLOCK_50); rdaddr_x = 6'd20; rdaddr_y = 5'd20;
        @(negedge CLOCK_50); check("b2b_0", int'(data), 0);   rdaddr_x = 6'd63; rdaddr_y = 5'd13;
        @(negedge CLOCK_50); check("b2b_1", int'(data), 255); rdaddr_x = 6'd16; rdaddr_y = 5'd13;
        @(negedge CLOCK_50); check("b2b_2", int'(data), 11);  rdaddr_x = 6'd40; rdaddr_y = 5'd0;
        @(negedge CLOCK_50); check("b2b_3", int'(data), 255); rdaddr_x = 6'd0;  rdaddr_y = 5'd0;
        @(negedge CLOCK_50); check("b2b_4", int'(data), 40);

        // Wall column at x=21 with a gap at y=5; trigger cycle read returns pre-clear value
        for (int y = 0; y < 30; y++) walls[21][y] = (y != 5);
        @(negedge CLOCK_50);
        rdaddr_x = 6'd16; rdaddr_y = 5'd13;
        curr_pacman_x = 6'd0; curr_pacman_y = 5'd0;
        @(negedge CLOCK_50);
        check("trigger_read_preclear", int'(data), 11);
        check("trigger_ready_drop", int'(ready), 0);
        curr_pacman_x = 6'd20; curr_pacman_y = 5'd20;
        wait_ready("wall_build", cyc);
        read_chk("wall_22_20", 6'd22, 5'd20, 32);
        read_chk("wall_21_10", 6'd21, 5'd10, 255);
        read_chk("wall_21_5",  6'd21, 5'd5,  16);
        read_chk("wall_20_5",  6'd20, 5'd5,  15);

        // Enclosed cell around (30,25)
        clear_walls();
        for (int x = 29; x <= 31; x++) begin walls[x][24] = 1'b1; walls[x][26] = 1'b1; end
        walls[29][25] = 1'b1;
        walls[31][25] = 1'b1;
        rebuild(6'd20, 5'd20);
        wait_ready("ring_build", cyc);
        read_chk("ring_30_25", 6'd30, 5'd25, 255);
        check("ring_ready", int'(ready), 1);
        read_chk("ring_32_25", 6'd32, 5'd25, 17);
        read_chk("ring_29_24", 6'd29, 5'd24, 255);

        // Pacman moves 500 cycles into BFS
        clear_walls();
        rebuild(6'd10, 5'd10);
        repeat (1202 + 500) @(posedge CLOCK_50);
        #1;
        check("midmove_ready_before", int'(ready), 0);
        @(negedge CLOCK_50);
        curr_pacman_x = 6'd5; curr_pacman_y = 5'd5;
        wait_ready("midmove_build", cyc);
        check("midmove_restart_lo", int'(cyc >= 12001), 1);
        check("midmove_restart_hi", int'(cyc <= 12004), 1);
        read_chk("midmove_5_5",   6'd5,  5'd5,  0);
        read_chk("midmove_0_0",   6'd0,  5'd0,  10);
        read_chk("midmove_10_10", 6'd10, 5'd10, 10);

        // Reset in the middle of BFS
        rebuild(6'd7, 5'd7);
        @(negedge CLOCK_50);
        rdaddr_x = 6'd7; rdaddr_y = 5'd7;
        repeat (3000) @(posedge CLOCK_50);
        #1;
        check("midreset_data_before", int'(data), 0);
        @(negedge CLOCK_50);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_ready", int'(ready), 0);
        check("midreset_data", int'(data), 255);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        wait_ready("postreset_build", cyc);
        check("postreset_lo", int'(cyc >= 12001), 1);
        check("postreset_hi", int'(cyc <= 12004), 1);
        read_chk("postreset_7_7", 6'd7, 5'd7, 0);
        read_chk("postreset_0_0", 6'd0, 5'd0, 14);
        read_chk("postreset_39_29", 6'd39, 5'd29, 54);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ghost_dist_map.md
Name: ghost_dist_map

Overview:
- Builds and serves the proximity map the ghost path controller reads. Each cell holds its shortest-path step count to pacman, computed by BFS flood fill over the maze wall map.
- Rebuilds whenever pacman's tile changes.
- Exposes a registered read port (rdaddr_x/rdaddr_y -> data, 1-cycle latency) and a ready flag. This is the responder end of the ghost controller's map-read interface.

Parameters:
- COLS, 40, grid width in tiles (x = 0..COLS-1).
- ROWS, 30, grid height in tiles (y = 0..ROWS-1).
- QDEPTH, 2048, BFS queue entries; must be >= COLS*ROWS.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- curr_pacman_x  in  6  pacman tile x.
- curr_pacman_y  in  5  pacman tile y.
- wall_rdaddr_x  out  6  wall-map read address x.
- wall_rdaddr_y  out  5  wall-map read address y.
- wall_data  in  1  wall bit for the address presented the previous cycle (1 = wall).
- rdaddr_x  in  6  consumer read address x.
- rdaddr_y  in  5  consumer read address y.
- data  out  8  distance at the previous cycle's rdaddr; 255 = wall, unreached or out of range.
- ready  out  1  map complete and consistent with the latched pacman tile.

Behaviour:
- Reset (async, reset_n=0):
  - state=CLEAR, cell counter=0.
  - Latched target = (63,31), so the first build is forced.
  - ready=0, data=255, wall_rdaddr=0. Queue empty.
- Internal storage: COLS*ROWS x 8-bit distance RAM.
  - Builder port: read/write.
  - Consumer port: registered read.
  - Consumer reads are always serviced, including during a build. Values are partial while ready=0.
- Consumer read:
  - data <= RAM[rdaddr] on the next edge.
  - If rdaddr_x>=COLS or rdaddr_y>=ROWS, data <= 255. This covers underflow from x-1 or y-1 wrapping to 63 or 31.
- Rebuild trigger:
  - Any cycle where curr_pacman differs from the latched target.
  - Latch the new target, ready<=0, go to CLEAR. The queue is flushed.
  - This applies in every state, including mid-CLEAR and mid-BFS.
- States:
  - CLEAR: write 255 to one cell per cycle in raster order. Takes exactly COLS*ROWS cycles, then go to SEED.
  - SEED:
    - Target in range: write 0 at the target and push (x,y,d=0). The target is seeded even if it is a wall.
    - Target out of range: go straight to DONE.
  - POP: queue empty -> DONE; otherwise dequeue (x,y,d) and take neighbours in order up, down, left, right.
  - N_ADDR: for the current neighbour, present its address on wall_rdaddr and read its distance.
    - Neighbours outside the grid are skipped: no wrap, and the slot still consumes its 2 cycles.
  - N_CHK: if wall_data=0 and stored distance==255:
    - write nd = min(d+1, 254);
    - push (nx,ny,nd).
    - Next neighbour -> N_ADDR; after the 4th -> POP.
  - Each dequeued cell costs exactly 9 cycles (1 POP + 4x2).
  - DONE: ready=1. Hold until the rebuild trigger fires.
- Each cell is enqueued at most once, so the queue never overflows with QDEPTH >= COLS*ROWS.
- Distance saturates at 254; 255 is reserved for walls and unreached cells.
- Walls are never written (they stay 255), except the seeded target.
- Simultaneous trigger and consumer read: the read returns the pre-clear value of that cycle. No stall.

Test Plan:
- Reset and first build:
  - Stimulus: reset_n=0, then release with pacman (20,20) and no walls.
  - Required: ready=0 during CLEAR (1200 cycles) and BFS; ready rises after 1200 + 1 + 1200*9 cycles.
- Open grid, pacman (20,20):
  - Read (16,13) -> data=11 one cycle later; (0,0) -> 40; (20,20) -> 0; (39,29) -> 28.
- Wall column:
  - Stimulus: walls at x=21 for all y except y=5; pacman (20,20).
  - Required: (22,20) -> 32; (21,10) -> 255; (21,5) -> 16.
- Out-of-range reads:
  - (63,13) -> 255; (16,31) -> 255; (40,0) -> 255.
  - Each response appears exactly one cycle after the address.
- Pacman moves mid-build:
  - Stimulus: change pacman to (5,5) 500 cycles into BFS.
  - Required: ready stays 0 and the build restarts from CLEAR; final map gives (5,5) -> 0 and (0,0) -> 10.
- Enclosed region:
  - Stimulus: ring of walls around (30,25).
  - Required: (30,25) -> 255 with ready=1.
- Reset mid-build:
  - Stimulus: assert reset_n=0 during BFS.
  - Required: ready=0 and data=255 immediately; a full rebuild follows release.
